// File: rtl/alu_branch_unit.sv
// AND/ADD datapath slice with Z register pair and CON branch flip-flop.
// Define ALU_OVF_EN to build the signed-overflow flag into V and ZHi[1].
module alu_branch_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] Y,
  input  logic [31:0] BusIn,
  input  logic        AND,
  input  logic        ADD,
  input  logic        CarryIn,
  input  logic        Zin,
  input  logic [3:0]  C2,
  input  logic        CONIn,
  output logic [31:0] ZHi,
  output logic [31:0] ZLo,
  output logic        CarryOut,
  output logic        V,
  output logic        BranchMet
);

  logic [31:0] r_zhi;
  logic [31:0] r_zlo;
  logic        r_bm;

  logic        w_and_sel;
  logic        w_add_sel;
  logic [31:0] w_and;
  logic [31:0] w_sum;
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [8:0]  w_gc;
  logic        w_vbit;
  logic        w_ld;
  logic [31:0] w_zhi_nxt;
  logic [31:0] w_zlo_nxt;
  logic [3:0]  w_dec;
  logic        w_zero;
  logic        w_neg;
  logic        w_cond;

  assign w_and_sel = AND;
  assign w_add_sel = ADD & ~AND;
  assign w_and     = Y & BusIn;
  assign w_g       = Y & BusIn;
  assign w_p       = Y ^ BusIn;
  assign w_gc[0]   = CarryIn;

  // Lookahead inside each nibble, ripple between nibbles.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cla
    logic [3:0] w_gg;
    logic [3:0] w_pp;
    logic [3:0] w_c;
    logic       w_grp_g;
    logic       w_grp_p;

    assign w_gg   = w_g[4*gi +: 4];
    assign w_pp   = w_p[4*gi +: 4];
    assign w_c[0] = w_gc[gi];
    assign w_c[1] = w_gg[0]
                  | (w_pp[0] & w_c[0]);
    assign w_c[2] = w_gg[1]
                  | (w_pp[1] & w_gg[0])
                  | (w_pp[1] & w_pp[0] & w_c[0]);
    assign w_c[3] = w_gg[2]
                  | (w_pp[2] & w_gg[1])
                  | (w_pp[2] & w_pp[1] & w_gg[0])
                  | (&w_pp[2:0] & w_c[0]);

    assign w_grp_g = w_gg[3]
                   | (w_pp[3] & w_gg[2])
                   | (w_pp[3] & w_pp[2] & w_gg[1])
                   | (&w_pp[3:1] & w_gg[0]);
    assign w_grp_p = &w_pp;

    assign w_gc[gi+1]       = w_grp_g | (w_grp_p & w_c[0]);
    assign w_sum[4*gi +: 4] = w_pp ^ w_c;
  end

  assign CarryOut = w_gc[8];

`ifdef ALU_OVF_EN
  assign V = w_add_sel
           & (Y[31] == BusIn[31])
           & (w_sum[31] != Y[31]);
`else
  assign V = 1'b0;
`endif

  assign w_vbit = V;

  always_comb begin
    w_ld      = 1'b0;
    w_zhi_nxt = r_zhi;
    w_zlo_nxt = r_zlo;
    unique case (1'b1)
      w_and_sel: begin
        w_ld      = Zin;
        w_zhi_nxt = 32'h0;
        w_zlo_nxt = w_and;
      end
      w_add_sel: begin
        w_ld      = Zin;
        w_zhi_nxt = {30'h0, w_vbit, w_gc[8]};
        w_zlo_nxt = w_sum;
      end
      default: ;
    endcase
  end

  assign w_zero = (BusIn == 32'h0);
  assign w_neg  = BusIn[31];
  assign w_dec  = 4'b0001 << C2[1:0];
  assign w_cond = |(w_dec & {w_neg, ~w_neg,
                             ~w_zero, w_zero});

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      r_zhi <= 32'h0;
      r_zlo <= 32'h0;
      r_bm  <= 1'b0;
    end else begin
      if (w_ld) begin
        r_zhi <= w_zhi_nxt;
        r_zlo <= w_zlo_nxt;
      end
      if (CONIn) r_bm <= w_cond;
    end
  end

  assign ZHi       = r_zhi;
  assign ZLo       = r_zlo;
  assign BranchMet = r_bm;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed self-checking bench for alu_branch_unit.
// Expected values track the ALU_OVF_EN build option.
module tb_alu_branch_unit;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [31:0] Y;
  logic [31:0] BusIn;
  logic        AND;
  logic        ADD;
  logic        CarryIn;
  logic        Zin;
  logic [3:0]  C2;
  logic        CONIn;
  logic [31:0] ZHi;
  logic [31:0] ZLo;
  logic        CarryOut;
  logic        V;
  logic        BranchMet;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef ALU_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  alu_branch_unit dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .Y         (Y),
    .BusIn     (BusIn),
    .AND       (AND),
    .ADD       (ADD),
    .CarryIn   (CarryIn),
    .Zin       (Zin),
    .C2        (C2),
    .CONIn     (CONIn),
    .ZHi       (ZHi),
    .ZLo       (ZLo),
    .CarryOut  (CarryOut),
    .V         (V),
    .BranchMet (BranchMet)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    AND = 0; ADD = 0; CarryIn = 0;
    Zin = 0; CONIn = 0;
  endtask

  logic [31:0] con_bus [3];
  logic [3:0]  con_exp [3];
  logic        bm_exp;

  initial begin
    con_bus[0] = 32'h0000_0000; con_exp[0] = 4'b0101;
    con_bus[1] = 32'h0000_0005; con_exp[1] = 4'b0110;
    con_bus[2] = 32'h8000_0000; con_exp[2] = 4'b1010;

    Clear = 1; Y = 0; BusIn = 0; C2 = 0;
    idle();
    #2;

    // load something first so reset has state to clear
    Y = 5; BusIn = 3; ADD = 1; Zin = 1;
    C2 = 4'b0001; CONIn = 1;
    tick();
    check("preload_zlo", ZLo, 32'h8);
    check("preload_bm", {31'h0, BranchMet}, 32'h1);

    Clear = 0; Y = 32'hFFFF_FFFF; BusIn = 32'h1;
    ADD = 1; Zin = 1; CONIn = 1; C2 = 4'b0001;
    tick();
    check("rst_zhi", ZHi, 32'h0);
    check("rst_zlo", ZLo, 32'h0);
    check("rst_bm", {31'h0, BranchMet}, 32'h0);
    Clear = 1;
    idle();

    Y = 32'h0000_00F0; BusIn = 32'h0000_0034;
    AND = 1; Zin = 1;
    tick();
    check("and_zlo", ZLo, 32'h30);
    check("and_zhi", ZHi, 32'h0);
    idle();

    Y = 32'hFFFF_FFFF; BusIn = 32'h1;
    ADD = 1; Zin = 1;
    #1;
    check("add_cout", {31'h0, CarryOut}, 32'h1);
    check("add_v0", {31'h0, V}, 32'h0);
    tick();
    check("add_zlo", ZLo, 32'h0);
    check("add_zhi", ZHi, 32'h1);
    idle();

    Y = 32'h7FFF_FFFF; BusIn = 32'h1;
    ADD = 1; Zin = 1;
    #1;
    check("ovf_v", {31'h0, V}, {31'h0, OVF});
    check("ovf_cout", {31'h0, CarryOut}, 32'h0);
    tick();
    check("ovf_zlo", ZLo, 32'h8000_0000);
    check("ovf_zhi", ZHi, {30'h0, OVF, 1'b0});
    idle();

    Y = 32'h8000_0000; BusIn = 32'h8000_0000;
    ADD = 1; Zin = 1;
    tick();
    check("negovf_zlo", ZLo, 32'h0);
    check("negovf_zhi", ZHi, {30'h0, OVF, 1'b1});
    idle();

    Y = 32'h10; BusIn = 32'h20; CarryIn = 1;
    ADD = 1; Zin = 1;
    tick();
    check("cin_zlo", ZLo, 32'h31);
    check("cin_zhi", ZHi, 32'h0);
    idle();

    Y = 32'h0F0F_0F0F; BusIn = 32'h0101_0101;
    ADD = 1; Zin = 1;
    tick();
    check("cla_zlo", ZLo, 32'h1010_1010);
    idle();

    for (int b = 0; b < 3; b++) begin
      for (int c = 0; c < 4; c++) begin
        BusIn = con_bus[b];
        C2 = c[3:0];
        CONIn = 1;
        tick();
        check($sformatf("con_b%0d_c%0d", b, c),
              {31'h0, BranchMet},
              {31'h0, con_exp[b][c]});
      end
    end
    idle();
    bm_exp = 1'b1;

    BusIn = 32'h0; C2 = 4'b0001;
    tick();
    check("con_hold", {31'h0, BranchMet},
          {31'h0, bm_exp});

    BusIn = 32'h0; C2 = 4'b1100; CONIn = 1;
    tick();
    check("con_hibits_zr", {31'h0, BranchMet}, 32'h1);
    BusIn = 32'h5; C2 = 4'b1011; CONIn = 1;
    tick();
    check("con_hibits_mi", {31'h0, BranchMet}, 32'h0);
    idle();

    Y = 32'hF0F0_F0F0; BusIn = 32'h0FF0_0FF0;
    AND = 1; ADD = 1; Zin = 1;
    tick();
    check("prio_zlo", ZLo, 32'h00F0_00F0);
    check("prio_zhi", ZHi, 32'h0);
    idle();

    Y = 32'h1234_5678; BusIn = 32'h1111_1111;
    Zin = 1;
    tick();
    check("hold_zlo", ZLo, 32'h00F0_00F0);
    check("hold_zhi", ZHi, 32'h0);
    idle();

    Y = 32'h1; BusIn = 32'h2;
    ADD = 1; Zin = 1; CONIn = 1; C2 = 4'b0001;
    tick();
    check("both_zlo", ZLo, 32'h3);
    check("both_bm", {31'h0, BranchMet}, 32'h1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Datapath slice holding the AND/ADD arithmetic path and the conditional-branch (CON) flip-flop of the CPU. It takes operand A from the Y register, operand B from the shared bus, and captures the selected result into the 64-bit Z register pair. In the same cycle structure it evaluates the branch-condition field of IR against the bus value and latches the outcome for the control unit.

## Interface
Parameters: none.

- Clock  in  1  system clock; all state updates on the rising edge.
- Clear  in  1  reset, synchronous, active-low. Sampled on the Clock rising edge.
- Y  in  32  operand A, driven from the Y register.
- BusIn  in  32  operand B for ALU operations; also the value tested by the CON logic.
- AND  in  1  select bitwise AND.
- ADD  in  1  select addition.
- CarryIn  in  1  adder carry-in (datapath ties 0 for plain ADD).
- Zin  in  1  load enable for ZHi/ZLo.
- C2  in  4  branch-condition field, IR[22:19].
- CONIn  in  1  load enable for the CON flip-flop.
- ZHi  out  32  registered high result word.
- ZLo  out  32  registered low result word.
- CarryOut  out  1  combinational adder carry-out for current operands.
- V  out  1  combinational signed-overflow flag (see Configuration).
- BranchMet  out  1  registered CON flip-flop output.

## Operation
- AND result: Y & BusIn, 32 bits.
- ADD result: {carry, sum} = Y + BusIn + CarryIn, unsigned 33-bit. Built as eight cascaded 4-bit carry-lookahead groups with group generate/propagate; carry ripples between groups.
- Op select: AND has priority over ADD when both are asserted. If neither is asserted, the ALU is idle.
- Z load, when Zin=1 and an op is selected:
  - AND: ZLo ← AND result; ZHi ← 0.
  - ADD: ZLo ← sum; ZHi ← {30'b0, Vbit, carry}. Vbit is V when ALU_OVF_EN is defined, else 0.
- Zin=1 with no op selected: ZHi/ZLo hold.
- CON condition uses C2[1:0]. C2[3:2] are ignored.
  - 00 brzr: BusIn == 0.
  - 01 brnz: BusIn != 0.
  - 10 brpl: BusIn[31] == 0.
  - 11 brmi: BusIn[31] == 1.
  - The two-bit field is decoded 2-to-4; the decoded lines are ANDed with the tests and ORed.
- BranchMet ← condition when CONIn=1, otherwise holds.
- The ALU and CON paths are independent. Zin and CONIn in the same cycle both take effect.

## Timing
- CarryOut and V are combinational, valid within the same cycle as the operands.
- ZHi/ZLo: 1-cycle latency. Operands presented in cycle n are visible after rising edge n.
- BranchMet: 1-cycle latency after the CONIn edge.
- Reset: Clear=0 at a rising edge forces ZHi=0, ZLo=0 and BranchMet=0.
  - Reset overrides Zin and CONIn in the same cycle.
  - Reset is effective mid-operation; no partial state survives.
- No handshake; enables are single-cycle level pulses from the control unit.
- Boundary cases:
  - 0xFFFFFFFF + 1 gives ZLo=0 and carry=1.
  - BusIn=0 satisfies both brzr and brpl.
  - BusIn=0x80000000 satisfies brnz and brmi.

## Configuration
- ALU_OVF_EN defined:
  - V = (Y[31] == BusIn[31]) && (sum[31] != Y[31]) during ADD; 0 otherwise.
  - On ADD loads, V is stored in ZHi[1].
- ALU_OVF_EN undefined:
  - V is tied 0 and ZHi[1] is always 0.
  - No overflow logic is synthesized; port list is unchanged.

## Test plan
- Reset: drive Clear=0 for 1 edge with Zin=CONIn=1 → ZHi=0, ZLo=0, BranchMet=0.
- AND: Y=0x0000_00F0, BusIn=0x0000_0034, AND=1, Zin=1 → next edge ZLo=0x0000_0030, ZHi=0.
- ADD with carry: Y=0xFFFF_FFFF, BusIn=0x0000_0001, ADD=1, Zin=1 → CarryOut=1 immediately; next edge ZLo=0, ZHi=0x0000_0001.
- Overflow, ALU_OVF_EN defined: Y=0x7FFF_FFFF, BusIn=1, ADD=1, Zin=1 → V=1; next edge ZLo=0x8000_0000, ZHi=0x0000_0002. Undefined: V=0, ZHi=0.
- CON sweep: for BusIn ∈ {0, 5, 0x8000_0000}, pulse CONIn with C2=0000/0001/0010/0011. BranchMet after each edge:
  - 0: 1/0/1/0.
  - 5: 0/1/1/0.
  - 0x8000_0000: 0/1/0/1.
  - Holds when CONIn=0.
- Priority/hold: AND=ADD=1 → AND result loaded. AND=ADD=0 with Zin=1 → Z unchanged. Zin and CONIn together → both update on the same edge.
